pe_fxp_dbuf: RTL and testbench

Parametrised successor to the systolic-array processing element. Signed fixed-point MAC with configurable width, fraction bits, double-buffered (shadow/active) weights and a sticky overflow flag. Sits at each grid point of the systolic array: inputs flow west→east, weights and partial sums flow north→south.

---
 rtl/pe_fxp_pkg.sv | 33 +++
 rtl/pe_fxp_mac.sv | 43 ++++
 rtl/pe_fxp_dbuf.sv | 71 +++++++
 tb/tb_pe_fxp_dbuf.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pe_fxp_pkg.sv
// Fixed-point helpers shared by the PE datapath: wide intermediate type,
// round-half-up shift, and signed range limits for a given word width.
package pe_fxp_pkg;

    localparam int PE_FXP_MAXW = 129;

    typedef logic signed [PE_FXP_MAXW-1:0] pe_wide_t;

    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int sum_width(input int dw);
        return 2 * dw + 1;
    endfunction

    // Adding half an LSB before the arithmetic shift gives round-half-up.
    function automatic pe_wide_t round_shift(input pe_wide_t p, input int frac);
        if (frac > 0)
            return (p + (pe_wide_t'(1) <<< (frac - 1))) >>> frac;
        else
            return p;
    endfunction

    function automatic pe_wide_t fxp_max(input int dw);
        return (pe_wide_t'(1) <<< (dw - 1)) - pe_wide_t'(1);
    endfunction

    function automatic pe_wide_t fxp_min(input int dw);
        return -(pe_wide_t'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/pe_fxp_mac.sv
// Combinational multiply, round, accumulate and range check for one PE.
// Out-of-range results wrap unless PE_FXP_SATURATE_EN is defined (then clamp).
module pe_fxp_mac
    import pe_fxp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic signed [DATA_WIDTH-1:0] act,
    input  logic signed [DATA_WIDTH-1:0] weight,
    input  logic signed [DATA_WIDTH-1:0] psum,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         overflow
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod;
    pe_wide_t             shifted;
    pe_wide_t             sum;
    pe_wide_t             max_w;
    pe_wide_t             min_w;

    always_comb begin
        prod     = PW'(act) * PW'(weight);
        shifted  = round_shift(pe_wide_t'(prod), FRAC_BITS);
        sum      = shifted + pe_wide_t'(psum);
        max_w    = fxp_max(DATA_WIDTH);
        min_w    = fxp_min(DATA_WIDTH);
        overflow = (sum > max_w) || (sum < min_w);
`ifdef PE_FXP_SATURATE_EN
        if (sum > max_w)
            result = max_w[DATA_WIDTH-1:0];
        else if (sum < min_w)
            result = min_w[DATA_WIDTH-1:0];
        else
            result = sum[DATA_WIDTH-1:0];
`else
        result = sum[DATA_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/pe_fxp_dbuf.sv
// Systolic-array PE: fixed-point MAC with shadow/active weight double buffer
// and sticky overflow. Build with PE_FXP_SATURATE_EN to clamp instead of wrap.
module pe_fxp_dbuf
    import pe_fxp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pe_enabled,
    input  logic signed [DATA_WIDTH-1:0] pe_psum_in,
    input  logic signed [DATA_WIDTH-1:0] pe_weight_in,
    input  logic                         pe_accept_w_in,
    input  logic signed [DATA_WIDTH-1:0] pe_input_in,
    input  logic                         pe_valid_in,
    input  logic                         pe_switch_in,
    output logic signed [DATA_WIDTH-1:0] pe_psum_out,
    output logic signed [DATA_WIDTH-1:0] pe_weight_out,
    output logic signed [DATA_WIDTH-1:0] pe_input_out,
    output logic                         pe_valid_out,
    output logic                         pe_switch_out,
    output logic                         pe_overflow
);

    logic signed [DATA_WIDTH-1:0] shadow_w;
    logic signed [DATA_WIDTH-1:0] active_w;
    logic signed [DATA_WIDTH-1:0] eff_w;
    logic signed [DATA_WIDTH-1:0] mac_result;
    logic                         mac_ovf;

    // A switch in this cycle makes the pre-edge shadow weight effective immediately.
    assign eff_w = pe_switch_in ? shadow_w : active_w;

    pe_fxp_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .act      (pe_input_in),
        .weight   (eff_w),
        .psum     (pe_psum_in),
        .result   (mac_result),
        .overflow (mac_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst || !pe_enabled) begin
            shadow_w      <= '0;
            active_w      <= '0;
            pe_psum_out   <= '0;
            pe_weight_out <= '0;
            pe_input_out  <= '0;
            pe_valid_out  <= 1'b0;
            pe_switch_out <= 1'b0;
            pe_overflow   <= 1'b0;
        end else begin
            pe_valid_out  <= pe_valid_in;
            pe_switch_out <= pe_switch_in;
            pe_input_out  <= pe_valid_in ? pe_input_in : '0;
            pe_weight_out <= pe_accept_w_in ? pe_weight_in : '0;
            pe_psum_out   <= pe_valid_in ? mac_result : '0;
            if (pe_accept_w_in)
                shadow_w <= pe_weight_in;
            if (pe_switch_in)
                active_w <= shadow_w;
            if (pe_valid_in && mac_ovf)
                pe_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_fxp_dbuf.sv
// Directed bench for pe_fxp_dbuf at default Q8.8; expected values hand-computed.
module tb_pe_fxp_dbuf;

    logic        clk;
    logic        rst;
    logic        pe_enabled;
    logic [15:0] pe_psum_in;
    logic [15:0] pe_weight_in;
    logic        pe_accept_w_in;
    logic [15:0] pe_input_in;
    logic        pe_valid_in;
    logic        pe_switch_in;
    logic [15:0] pe_psum_out;
    logic [15:0] pe_weight_out;
    logic [15:0] pe_input_out;
    logic        pe_valid_out;
    logic        pe_switch_out;
    logic        pe_overflow;

    int checks = 0;
    int errors = 0;

`ifdef PE_FXP_SATURATE_EN
    localparam logic [15:0] EXP_OVF_POS  = 16'h7FFF;
    localparam logic [15:0] EXP_MOST_NEG = 16'h7FFF;
    localparam logic [15:0] EXP_OVF_NEG  = 16'h8000;
`else
    localparam logic [15:0] EXP_OVF_POS  = 16'h7EFF;
    localparam logic [15:0] EXP_MOST_NEG = 16'h0000;
    localparam logic [15:0] EXP_OVF_NEG  = 16'h8080;
`endif

    pe_fxp_dbuf #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .pe_enabled     (pe_enabled),
        .pe_psum_in     (pe_psum_in),
        .pe_weight_in   (pe_weight_in),
        .pe_accept_w_in (pe_accept_w_in),
        .pe_input_in    (pe_input_in),
        .pe_valid_in    (pe_valid_in),
        .pe_switch_in   (pe_switch_in),
        .pe_psum_out    (pe_psum_out),
        .pe_weight_out  (pe_weight_out),
        .pe_input_out   (pe_input_out),
        .pe_valid_out   (pe_valid_out),
        .pe_switch_out  (pe_switch_out),
        .pe_overflow    (pe_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] psum, input logic [15:0] wout,
                           input logic [15:0] iout, input logic vout, input logic sout,
                           input logic ovf);
        chk({tag, ".psum"},   pe_psum_out,           psum);
        chk({tag, ".weight"}, pe_weight_out,         wout);
        chk({tag, ".input"},  pe_input_out,          iout);
        chk({tag, ".valid"},  {15'd0, pe_valid_out}, {15'd0, vout});
        chk({tag, ".switch"}, {15'd0, pe_switch_out}, {15'd0, sout});
        chk({tag, ".ovf"},    {15'd0, pe_overflow},  {15'd0, ovf});
    endtask

    task automatic drive(input logic acc, input logic [15:0] w, input logic sw,
                         input logic vld, input logic [15:0] in, input logic [15:0] ps);
        pe_accept_w_in = acc;
        pe_weight_in   = w;
        pe_switch_in   = sw;
        pe_valid_in    = vld;
        pe_input_in    = in;
        pe_psum_in     = ps;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pe_enabled = 1'b1;
        drive(1'b1, 16'h5555, 1'b1, 1'b1, 16'h1111, 16'h2222);
        cyc();
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Basic Q8.8 MAC: 1.5 * 2.0 + 1.0 = 4.0
        rst = 1'b0;
        drive(1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc();
        chk_all("load2", 16'h0000, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000);
        cyc();
        chk_all("switch2", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0180, 16'h0100);
        cyc();
        chk_all("mac_basic", 16'h0400, 16'h0000, 16'h0180, 1'b1, 1'b0, 1'b0);

        // Simultaneous accept and switch: old shadow becomes effective
        drive(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc();
        drive(1'b1, 16'h0300, 1'b1, 1'b1, 16'h0100, 16'h0000);
        cyc();
        chk_all("acc_sw", 16'h0100, 16'h0300, 16'h0100, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h0000);
        cyc();
        chk("sw_new.psum", pe_psum_out, 16'h0300);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 16'h0000);
        cyc();
        chk("active_hold.psum", pe_psum_out, 16'h0300);

        // Rounding with weight of one LSB
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc();
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0080, 16'h0000);
        cyc();
        chk("round_half.psum", pe_psum_out, 16'h0001);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h007F, 16'h0000);
        cyc();
        chk("round_below.psum", pe_psum_out, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFF80, 16'h0000);
        cyc();
        chk("round_neg_half.psum", pe_psum_out, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFF7F, 16'h0000);
        cyc();
        chk("round_neg.psum", pe_psum_out, 16'hFFFF);
        chk("round_neg.ovf", {15'd0, pe_overflow}, 16'h0000);

        // Positive overflow, then sticky over clean MACs and idle cycles
        drive(1'b1, 16'h7FFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc();
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 16'h7FFF);
        cyc();
        chk("ovf_pos.psum", pe_psum_out, EXP_OVF_POS);
        chk("ovf_pos.ovf", {15'd0, pe_overflow}, 16'h0001);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0005);
        cyc();
        chk("sticky_clean.psum", pe_psum_out, 16'h0005);
        chk("sticky_clean.ovf", {15'd0, pe_overflow}, 16'h0001);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000);
        cyc();
        chk_all("sticky_idle", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Reset mid-stream clears weights and overflow
        rst = 1'b1;
        drive(1'b1, 16'h0400, 1'b1, 1'b1, 16'h0100, 16'h0100);
        cyc();
        chk_all("mid_reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 16'h0123);
        cyc();
        chk_all("post_reset", 16'h0123, 16'h0000, 16'h0100, 1'b1, 1'b0, 1'b0);

        // Most-negative squared, then negative overflow
        drive(1'b1, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc();
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'h0000);
        cyc();
        chk("most_neg.psum", pe_psum_out, EXP_MOST_NEG);
        chk("most_neg.ovf", {15'd0, pe_overflow}, 16'h0001);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h7FFF, 16'h8000);
        cyc();
        chk("ovf_neg.psum", pe_psum_out, EXP_OVF_NEG);

        // Disable behaves like reset, including weights
        pe_enabled = 1'b0;
        drive(1'b1, 16'h1111, 1'b1, 1'b1, 16'h1234, 16'h0042);
        cyc();
        chk_all("disabled", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        pe_enabled = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h0042);
        cyc();
        chk("reenable_sw.psum", pe_psum_out, 16'h0042);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 16'h0042);
        cyc();
        chk("reenable_act.psum", pe_psum_out, 16'h0042);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0042);
        cyc();
        chk_all("invalid_in", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
